// File: rtl/test_ctrl.sv
// test_ctrl: test-harness sequencer around a CPU under test.
// Holds the CPU in reset, copies a program image from a read-latency-1 source
// into instruction memory over a valid/ready port, releases the CPU, then
// watches its MMIO stores for a TOHOST result or a run-cycle timeout.
// Optional feature: define TEST_CTRL_CONSOLE_EN to add a one-byte console
// output port (con_valid/con_data) fed by stores to CONSOLE_ADDR.
module test_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned PROG_WORDS   = 256,
  parameter int unsigned RST_CYCLES   = 5,
  parameter int unsigned TIMEOUT      = 100000,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_F000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_F004
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [XLEN-1:0]   src_rd_data,
  output logic              ld_valid,
  input  logic              ld_ready,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [XLEN-1:0]   ld_data,
  input  logic              mmio_we,
  input  logic [XLEN-1:0]   mmio_addr,
  input  logic [XLEN-1:0]   mmio_wdata,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_code,
  output logic [31:0]       cycle_count
`ifdef TEST_CTRL_CONSOLE_EN
  ,
  output logic              con_valid,
  output logic [7:0]        con_data
`endif
);

  localparam int unsigned      CntW       = ADDR_W + 1;
  localparam logic [CntW-1:0]  ProgWordsC = CntW'(PROG_WORDS);
  localparam logic [XLEN-1:0]  TohostA    = XLEN'(TOHOST_ADDR);
  localparam logic [31:0]      LastCycle  = 32'(TIMEOUT - 1);
  // A TOHOST address aliased onto the console must never end the test.
  localparam bit               TohostLive = (TOHOST_ADDR != CONSOLE_ADDR);

  typedef enum logic [1:0] {StHold, StLoad, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [31:0]         hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0]     issue_cnt_q, issue_cnt_d;   // reads issued = next source index
  logic                ld_valid_q, ld_valid_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic                stall_q, stall_d;           // load word parked in stall_data_q
  logic [XLEN-1:0]     stall_data_q, stall_data_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [XLEN-2:0]     fail_code_q, fail_code_d;
  logic [31:0]         cycle_count_q, cycle_count_d;

  logic xfer, all_issued, issue, hold_last, tohost_hit, timeout_hit;

  // Handshake and event decode shared by next-state logic.
  always_comb begin
    xfer        = ld_valid_q & ld_ready;
    all_issued  = (issue_cnt_q == ProgWordsC);
    // Issue the next read only when the output slot is free by the next edge.
    issue       = (state_q == StLoad) && !all_issued && (!ld_valid_q || xfer);
    hold_last   = ((hold_cnt_q + 32'd1) >= 32'(RST_CYCLES));
    tohost_hit  = TohostLive && mmio_we && (mmio_addr == TohostA) && mmio_wdata[0];
    timeout_hit = (cycle_count_q == LastCycle);
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    issue_cnt_d   = issue_cnt_q;
    ld_valid_d    = ld_valid_q;
    ld_addr_d     = ld_addr_q;
    stall_d       = stall_q;
    stall_data_d  = stall_data_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      StHold: begin
        if (hold_last) begin
          hold_cnt_d = '0;
          state_d    = (ProgWordsC == '0) ? StRun : StLoad;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      StLoad: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CntW'(1);
          ld_valid_d  = 1'b1;
          ld_addr_d   = issue_cnt_q[ADDR_W-1:0];
        end else if (xfer) begin
          ld_valid_d  = 1'b0;
        end
        // Source data is only valid for one cycle; park it on the first stall cycle.
        if (xfer) begin
          stall_d = 1'b0;
        end else if (ld_valid_q && !stall_q) begin
          stall_d      = 1'b1;
          stall_data_d = src_rd_data;
        end
        if (all_issued && (!ld_valid_q || xfer)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A qualifying TOHOST store takes priority over a same-cycle timeout.
        if (tohost_hit) begin
          state_d     = StDone;
          done_d      = 1'b1;
          pass_d      = (mmio_wdata == XLEN'(1));
          fail_code_d = mmio_wdata[XLEN-1:1];
          timeout_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d     = StDone;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_code_d = '0;
          timeout_d   = 1'b1;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StHold;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StHold;
      hold_cnt_q    <= '0;
      issue_cnt_q   <= '0;
      ld_valid_q    <= 1'b0;
      ld_addr_q     <= '0;
      stall_q       <= 1'b0;
      stall_data_q  <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      issue_cnt_q   <= issue_cnt_d;
      ld_valid_q    <= ld_valid_d;
      ld_addr_q     <= ld_addr_d;
      stall_q       <= stall_d;
      stall_data_q  <= stall_data_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Load data comes straight from the source on the first valid cycle, then from the park.
  always_comb begin
    ld_data = '0;
    if (ld_valid_q) begin
      ld_data = stall_q ? stall_data_q : src_rd_data;
    end
  end

  assign cpu_rst_n   = (state_q == StRun);
  assign src_rd_addr = issue_cnt_q[ADDR_W-1:0];
  assign ld_valid    = ld_valid_q;
  assign ld_addr     = ld_addr_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

`ifdef TEST_CTRL_CONSOLE_EN
  localparam logic [XLEN-1:0] ConsoleA = XLEN'(CONSOLE_ADDR);

  logic       con_valid_q, con_valid_d;
  logic [7:0] con_data_q, con_data_d;

  // Console byte strobe: one pulse per store to CONSOLE_ADDR while running.
  always_comb begin
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;
    if ((state_q == StRun) && mmio_we && (mmio_addr == ConsoleA)) begin
      con_valid_d = 1'b1;
      con_data_d  = mmio_wdata[7:0];
    end
  end

  // Console output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
    end else begin
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
    end
  end

  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;
`endif

endmodule

// File: tb/tb_test_ctrl.sv
// Directed bench for test_ctrl: hold/load timing, stalled load handshake,
// TOHOST pass/fail, timeout, mid-load reset and (when built with
// TEST_CTRL_CONSOLE_EN) the console strobe.
module tb_test_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 16;
  localparam int unsigned NW   = 4;
  localparam int unsigned RC   = 5;
  localparam int unsigned TO   = 50;
  localparam logic [31:0] TOHOST  = 32'h0000_F000;
  localparam logic [31:0] CONSOLE = 32'h0000_F004;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpu_rst_n;
  logic [AW-1:0]   src_rd_addr;
  logic [XLEN-1:0] src_rd_data = '0;
  logic            ld_valid;
  logic            ld_ready = 1'b1;
  logic [AW-1:0]   ld_addr;
  logic [XLEN-1:0] ld_data;
  logic            mmio_we = 1'b0;
  logic [XLEN-1:0] mmio_addr = '0;
  logic [XLEN-1:0] mmio_wdata = '0;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [XLEN-2:0] fail_code;
  logic [31:0]     cycle_count;
`ifdef TEST_CTRL_CONSOLE_EN
  logic            con_valid;
  logic [7:0]      con_data;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_xfer;
  int n_stall;
  int n_wait;
  bit stalled_prev;
  logic [AW-1:0]   sv_addr;
  logic [AW-1:0]   sv_src;
  logic [XLEN-1:0] sv_data;

  test_ctrl #(
    .XLEN        (XLEN),
    .ADDR_W      (AW),
    .PROG_WORDS  (NW),
    .RST_CYCLES  (RC),
    .TIMEOUT     (TO),
    .TOHOST_ADDR (TOHOST),
    .CONSOLE_ADDR(CONSOLE)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_rst_n  (cpu_rst_n),
    .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count)
`ifdef TEST_CTRL_CONSOLE_EN
    ,
    .con_valid  (con_valid),
    .con_data   (con_data)
`endif
  );

  always #5 clk = ~clk;

  // Distinct word per source address.
  function automatic logic [31:0] src_word(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Program source: synchronous read, data one cycle after address.
  always @(posedge clk) src_rd_data <= src_word(src_rd_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mmio_we    = 1'b1;
    mmio_addr  = a;
    mmio_wdata = d;
    tick();
    mmio_we    = 1'b0;
  endtask

  // Reset, then run hold and load with ld_ready high until the CPU is released.
  task automatic run_to_run();
    int n;
    rst_n    = 1'b0;
    mmio_we  = 1'b0;
    ld_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!cpu_rst_n && n < 40) begin
      tick();
      n++;
    end
    check_val("reach_run", 32'(cpu_rst_n), 32'd1);
    check_val("run_cc0", cycle_count, 32'd0);
  endtask

  initial begin
    // Reset values.
    rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("rst_ld_valid", 32'(ld_valid), 32'd0);
    check_val("rst_src_addr", 32'(src_rd_addr), 32'd0);
    check_val("rst_ld_addr", 32'(ld_addr), 32'd0);
    check_val("rst_ld_data", ld_data, 32'd0);
    check_val("rst_flags", {29'd0, done, pass, timeout}, 32'd0);
    check_val("rst_fail_code", 32'(fail_code), 32'd0);
    check_val("rst_cycle_count", cycle_count, 32'd0);

    // Hold: CPU in reset, no load for RC cycles.
    rst_n = 1'b1;
    for (int k = 0; k < int'(RC); k++) begin
      tick();
      check_val("hold_cpu_ld", {30'd0, cpu_rst_n, ld_valid}, 32'd0);
    end
    check_val("load_first_addr", 32'(src_rd_addr), 32'd0);
    tick();

    // Load with word 1 stalled for 3 cycles.
    n_xfer = 0;
    n_stall = 0;
    stalled_prev = 1'b0;
    for (int c = 0; c < 16 && n_xfer < int'(NW); c++) begin
      check_val("ld_valid_hi", 32'(ld_valid), 32'd1);
      if (stalled_prev) begin
        check_val("stall_addr", 32'(ld_addr), 32'(sv_addr));
        check_val("stall_data", ld_data, sv_data);
        check_val("stall_src", 32'(src_rd_addr), 32'(sv_src));
      end
      ld_ready = !(n_xfer == 1 && n_stall < 3);
      if (ld_ready) begin
        check_val("xfer_addr", 32'(ld_addr), 32'(n_xfer));
        check_val("xfer_data", ld_data, src_word(AW'(n_xfer)));
        n_xfer++;
        stalled_prev = 1'b0;
      end else begin
        n_stall++;
        stalled_prev = 1'b1;
        sv_addr = ld_addr;
        sv_data = ld_data;
        sv_src  = src_rd_addr;
      end
      tick();
    end
    check_val("xfer_count", 32'(n_xfer), 32'(NW));
    check_val("post_load_valid", 32'(ld_valid), 32'd0);
    check_val("post_load_cpu", 32'(cpu_rst_n), 32'd1);
    check_val("post_load_cc", cycle_count, 32'd0);

    // Fail code 3; even stores and other addresses are ignored.
    tick();
    tick();
    tick();
    check_val("run_cc3", cycle_count, 32'd3);
    store(TOHOST, 32'h6);
    check_val("even_tohost_ign", 32'(done), 32'd0);
    store(TOHOST + 32'd8, 32'h1);
    check_val("other_addr_ign", {30'd0, done, cpu_rst_n}, 32'd1);
    store(TOHOST, 32'h7);
    check_val("f7_flags", {28'd0, done, pass, timeout, cpu_rst_n}, 32'b1000);
    check_val("f7_fail_code", 32'(fail_code), 32'd3);
    check_val("f7_cc", cycle_count, 32'd5);
    store(TOHOST, 32'h1);
    tick();
    check_val("done_frozen", {29'd0, done, pass, timeout}, 32'b100);
    check_val("done_cc_frozen", cycle_count, 32'd5);
    check_val("done_fc_frozen", 32'(fail_code), 32'd3);

    // Pass.
    run_to_run();
    tick();
    tick();
    store(TOHOST, 32'h1);
    check_val("p1_flags", {28'd0, done, pass, timeout, cpu_rst_n}, 32'b1100);
    check_val("p1_fail_code", 32'(fail_code), 32'd0);
    check_val("p1_cc", cycle_count, 32'd2);

    // Timeout.
    run_to_run();
    for (int k = 0; k < int'(TO) - 1; k++) tick();
    check_val("to_cc_last", cycle_count, 32'(TO - 1));
    check_val("to_not_yet", 32'(done), 32'd0);
    tick();
    check_val("to_flags", {28'd0, done, pass, timeout, cpu_rst_n}, 32'b1010);
    check_val("to_fail_code", 32'(fail_code), 32'd0);
    check_val("to_cc", cycle_count, 32'(TO - 1));

    // Store on the timeout cycle wins.
    run_to_run();
    for (int k = 0; k < int'(TO) - 1; k++) tick();
    store(TOHOST, 32'h1);
    check_val("race_flags", {29'd0, done, pass, timeout}, 32'b110);
    check_val("race_cc", cycle_count, 32'(TO - 1));

    // Reset clears a finished test.
    rst_n = 1'b0;
    tick();
    check_val("rst2_flags", {29'd0, done, pass, timeout}, 32'd0);
    check_val("rst2_cc", cycle_count, 32'd0);

    // Reset in the middle of the load.
    rst_n = 1'b1;
    ld_ready = 1'b1;
    n_wait = 0;
    while (!(ld_valid && ld_addr == AW'(2)) && n_wait < 30) begin
      tick();
      n_wait++;
    end
    check_val("reach_w2", 32'(ld_addr), 32'd2);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_valid", 32'(ld_valid), 32'd0);
    check_val("mid_rst_addrs", {ld_addr, src_rd_addr}, 32'd0);
    check_val("mid_rst_data", ld_data, 32'd0);
    check_val("mid_rst_cpu", 32'(cpu_rst_n), 32'd0);
    rst_n = 1'b1;
    n_wait = 0;
    while (!ld_valid && n_wait < 30) begin
      tick();
      n_wait++;
    end
    check_val("restart_latency", 32'(n_wait), 32'(RC + 1));
    check_val("restart_addr", 32'(ld_addr), 32'd0);
    check_val("restart_data", ld_data, src_word(AW'(0)));
    n_wait = 0;
    while (!cpu_rst_n && n_wait < 30) begin
      tick();
      n_wait++;
    end
    check_val("restart_run", 32'(cpu_rst_n), 32'd1);

    // Console store never ends the test.
    store(CONSOLE, 32'h41);
    check_val("con_no_done", {30'd0, done, cpu_rst_n}, 32'd1);
`ifdef TEST_CTRL_CONSOLE_EN
    check_val("con_valid", 32'(con_valid), 32'd1);
    check_val("con_data", 32'(con_data), 32'h41);
    tick();
    check_val("con_pulse_end", 32'(con_valid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
